mod_exp_ctrl: RTL and testbench

Modular exponentiation sequencer: computes result = base^exp mod p by left-to-right square-and-multiply. It is the initiator that drives an external modular multiplier (the ModMul enable/reset/done interface) and consumes its results. It sits above the multiplier in the MSM datapath. Its main use is Fermat inversion (exp = p-2) and scalar powers.

---
 rtl/mod_exp_ctrl.sv | 150 +++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// rtl/mod_exp_ctrl.sv - left-to-right square-and-multiply sequencer driving an external modular multiplier
module mod_exp_ctrl #(
  parameter int p      = 37,
  parameter int width  = 128,
  parameter int ewidth = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [width-1:0]  base,
  input  logic [ewidth-1:0] exp,
  output logic              busy,
  output logic              done,
  output logic [width-1:0]  result,
  output logic [width-1:0]  mul_a,
  output logic [width-1:0]  mul_b,
  output logic              mul_reset,
  output logic              mul_enable,
  input  logic              mul_done,
  input  logic [width-1:0]  mul_r,
  output logic [15:0]       mul_ops
);

  localparam int iw = (ewidth > 1) ? $clog2(ewidth) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, NEXT, FIN} state_t;

  state_t            state, state_nx;
  logic [width-1:0]  acc;
  logic [width-1:0]  base_q;
  logic [ewidth-1:0] exp_q;
  logic [iw-1:0]     idx;
  logic              step_mul;
  logic              wait_first;

  logic              load_op, load_mul, idx_dec, acc_from_base, acc_one, take_r;
  logic [width-1:0]  op_a, op_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    load_op       = 1'b0;
    load_mul      = 1'b0;
    idx_dec       = 1'b0;
    acc_from_base = 1'b0;
    acc_one       = 1'b0;
    take_r        = 1'b0;
    op_a          = acc;
    op_b          = acc;
    mul_enable    = 1'b0;
    mul_reset     = 1'b1;
    case (state)
      IDLE: if (start) state_nx = SCAN;
      SCAN: begin
        if (exp_q[idx]) begin
          acc_from_base = 1'b1;
          if (idx == '0) begin
            state_nx = FIN;
          end else begin
            // first op squares the base directly; acc is loaded on the same edge
            idx_dec  = 1'b1;
            load_op  = 1'b1;
            op_a     = base_q;
            op_b     = base_q;
            state_nx = ISSUE;
          end
        end else if (idx == '0) begin
          acc_one  = 1'b1;
          state_nx = FIN;
        end else begin
          idx_dec = 1'b1;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        mul_enable = 1'b1;
        mul_reset  = 1'b0;
        // a done left high by the previous op must not complete this one
        if (mul_done && !wait_first) begin
          take_r   = 1'b1;
          state_nx = NEXT;
        end
      end
      NEXT: begin
        if (!step_mul && exp_q[idx]) begin
          load_op  = 1'b1;
          load_mul = 1'b1;
          op_b     = base_q;
          state_nx = ISSUE;
        end else if (idx == '0) begin
          state_nx = FIN;
        end else begin
          idx_dec  = 1'b1;
          load_op  = 1'b1;
          state_nx = ISSUE;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_ops    <= '0;
      acc        <= '0;
      base_q     <= '0;
      exp_q      <= '0;
      idx        <= '0;
      step_mul   <= 1'b0;
      wait_first <= 1'b0;
    end else begin
      done       <= (state == FIN);
      wait_first <= (state == ISSUE);
      if (state == IDLE && start) begin
        base_q  <= base;
        exp_q   <= exp;
        idx     <= iw'(ewidth - 1);
        mul_ops <= '0;
        busy    <= 1'b1;
      end
      if (state == FIN) begin
        busy   <= 1'b0;
        result <= acc;
      end
      if (acc_from_base) acc <= base_q;
      if (acc_one)       acc <= (p == 1) ? '0 : width'(1);
      if (take_r) begin
        acc <= mul_r;
        if (mul_ops != 16'hFFFF) mul_ops <= mul_ops + 16'd1;
      end
      if (idx_dec) idx <= idx - 1'b1;
      if (load_op) begin
        mul_a    <= op_a;
        mul_b    <= op_b;
        step_mul <= load_mul;
      end
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb/tb_mod_exp_ctrl.sv - self-checking bench for mod_exp_ctrl with a behavioural modular multiplier
module tb_mod_exp_ctrl;
  localparam int P  = 37;
  localparam int W  = 128;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  base_s = '0;
  logic [EW-1:0] exp_s = '0;
  logic          busy, done, mul_reset, mul_enable;
  logic [W-1:0]  result, mul_a, mul_b;
  logic          mul_done = 1'b0;
  logic [W-1:0]  mul_r = '0;
  logic [15:0]   mul_ops;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.p(P), .width(W), .ewidth(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base_s), .exp(exp_s),
    .busy(busy), .done(done), .result(result), .mul_a(mul_a), .mul_b(mul_b),
    .mul_reset(mul_reset), .mul_enable(mul_enable), .mul_done(mul_done),
    .mul_r(mul_r), .mul_ops(mul_ops)
  );

  // behavioural multiplier; stale_mode keeps done/r alive through its reset
  bit           stale_mode = 1'b0;
  int           mm_cnt = 0;
  int           mm_lat = 3;
  logic [W-1:0] mm_a = '0, mm_b = '0;

  always @(posedge clk) begin
    if (mul_reset) begin
      mm_cnt <= 0;
      if (!stale_mode) mul_done <= 1'b0;
    end else if (mul_enable) begin
      if (mm_cnt == 0) begin
        mul_done <= 1'b0;
        mm_a     <= mul_a;
        mm_b     <= mul_b;
        mm_lat   <= int'($urandom_range(3, 40));
        mm_cnt   <= 1;
      end else if (mm_cnt < mm_lat) begin
        mm_cnt <= mm_cnt + 1;
      end else if (mm_cnt == mm_lat) begin
        mul_done <= 1'b1;
        mul_r    <= (mm_a * mm_b) % P;
        mm_cnt   <= mm_cnt + 1;
      end
    end
  end

  // protocol monitor
  int           en_rises = 0, done_cnt = 0, gap_err = 0, stab_err = 0;
  logic         prev_en = 1'b0, prev_rst = 1'b1;
  logic [W-1:0] prev_a = '0, prev_b = '0;

  always @(negedge clk) begin
    if (mul_enable && !prev_en) begin
      en_rises <= en_rises + 1;
      if (!prev_rst) gap_err <= gap_err + 1;
    end
    if (mul_enable && prev_en && (mul_a != prev_a || mul_b != prev_b)) stab_err <= stab_err + 1;
    if (done) done_cnt <= done_cnt + 1;
    prev_en  <= mul_enable;
    prev_rst <= mul_reset;
    prev_a   <= mul_a;
    prev_b   <= mul_b;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic int unsigned ref_pow(input int unsigned b, input int unsigned e);
    int unsigned r;
    r = 1 % P;
    for (int k = 0; k < int'(e); k++) r = (r * b) % P;
    return r;
  endfunction

  function automatic int unsigned ref_ops(input int unsigned e);
    int bl, pc;
    bl = 0;
    pc = 0;
    if (e == 0) return 0;
    for (int k = 0; k < 32; k++) if (e[k]) begin pc++; bl = k + 1; end
    return int'(bl - 1 + pc - 1);
  endfunction

  task automatic run_exp(input int unsigned b, input int unsigned e, input int unsigned want_r,
                         input int unsigned want_ops, input bit interfere, input string tag,
                         output int cyc);
    int en0, dn0, gap0, stab0;
    bit got, sent;
    @(negedge clk);
    en0 = en_rises; dn0 = done_cnt; gap0 = gap_err; stab0 = stab_err;
    base_s = W'(b);
    exp_s  = EW'(e);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, W'(busy), W'(1));
    got = 1'b0; sent = 1'b0; cyc = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin got = 1'b1; break; end
      if (interfere && !sent && mul_enable) begin
        start = 1'b1; base_s = W'(3); exp_s = EW'(36); sent = 1'b1;
      end
    end
    start = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done within 5000 cycles", tag);
      return;
    end
    chk({tag, " result"}, result, W'(want_r));
    chk({tag, " mul_ops"}, W'(mul_ops), W'(want_ops));
    chk({tag, " busy_at_done"}, W'(busy), W'(0));
    @(negedge clk);
    chk({tag, " done_single"}, W'(done), W'(0));
    @(negedge clk);
    chk({tag, " done_pulses"}, W'(done_cnt - dn0), W'(1));
    chk({tag, " ops_seen"}, W'(en_rises - en0), W'(want_ops));
    chk({tag, " reset_gap"}, W'(gap_err - gap0), W'(0));
    chk({tag, " operand_stable"}, W'(stab_err - stab0), W'(0));
  endtask

  typedef struct {
    int unsigned b;
    int unsigned e;
    int unsigned r;
    int unsigned ops;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int cyc;
    int unsigned rb, re;
    tbl[0] = '{2, 5, 32, 3};
    tbl[1] = '{5, 35, 15, 7};
    tbl[2] = '{3, 36, 1, 6};
    tbl[3] = '{7, 0, 1, 0};
    tbl[4] = '{9, 1, 9, 0};
    tbl[5] = '{4, 3, 27, 2};
    tbl[6] = '{36, 255, 36, 14};
    tbl[7] = '{1, 128, 1, 7};

    repeat (3) @(negedge clk);
    chk("rst busy", W'(busy), W'(0));
    chk("rst done", W'(done), W'(0));
    chk("rst result", result, W'(0));
    chk("rst mul_a", mul_a, W'(0));
    chk("rst mul_b", mul_b, W'(0));
    chk("rst mul_enable", W'(mul_enable), W'(0));
    chk("rst mul_reset", W'(mul_reset), W'(1));
    chk("rst mul_ops", W'(mul_ops), W'(0));
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_exp(tbl[i].b, tbl[i].e, tbl[i].r, tbl[i].ops, 1'b0, $sformatf("vec%0d", i), cyc);
      if (tbl[i].e == 0) chk("exp0 latency", W'(cyc), W'(EW + 1));
    end

    // start while a multiplication is in flight must be ignored
    run_exp(2, 5, 32, 3, 1'b1, "start_in_wait", cyc);

    // asynchronous reset in the middle of WAIT
    @(negedge clk);
    base_s = W'(2); exp_s = EW'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!mul_enable && cyc < 200) begin @(negedge clk); cyc++; end
    chk("reach_wait", W'(mul_enable), W'(1));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst busy", W'(busy), W'(0));
    chk("midrst mul_enable", W'(mul_enable), W'(0));
    chk("midrst mul_reset", W'(mul_reset), W'(1));
    chk("midrst result", result, W'(0));
    chk("midrst mul_ops", W'(mul_ops), W'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_exp(4, 3, 27, 2, 1'b0, "after_reset", cyc);

    // stale done carried into the next op's first WAIT cycle
    stale_mode = 1'b1;
    run_exp(3, 36, 1, 6, 1'b0, "stale_a", cyc);
    run_exp(5, 35, 15, 7, 1'b0, "stale_b", cyc);
    run_exp(2, 5, 32, 3, 1'b0, "stale_c", cyc);
    stale_mode = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      rb = $urandom_range(0, P - 1);
      re = $urandom_range(0, 255);
      run_exp(rb, re, ref_pow(rb, re), ref_ops(re), 1'b0, $sformatf("rnd%0d b=%0d e=%0d", i, rb, re), cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
